// File: rtl/factorial_pkg.sv
// Shared types and defaults for the iterative factorial engine.
package factorial_pkg;

    localparam int unsigned W_DEF  = 32;
    localparam int unsigned NW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/factorial_engine_sat_mul.sv
// W-by-NW unsigned multiply: low W product bits plus a flag for any nonzero upper bits.
module sat_mul #(
    parameter int unsigned W  = 32,
    parameter int unsigned NW = 8
) (
    input  logic [W-1:0]  a,
    input  logic [NW-1:0] b,
    output logic [W-1:0]  lo,
    output logic          ovf
);

    localparam int unsigned PW = W + NW;

    logic [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);
    assign lo   = prod[W-1:0];
    assign ovf  = |prod[PW-1:W];

endmodule

// File: rtl/factorial_engine.sv
// Sequential n! engine: one multiply per clock, saturating to all-ones on overflow.
module factorial_engine
    import factorial_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [NW-1:0] in_n,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_fact,
    output logic          out_ovf,
    output logic          busy
);

    state_t        state, state_next;
    logic [W-1:0]  acc, acc_next;
    logic [NW-1:0] cnt, cnt_next;
    logic          ovf, ovf_next;

    logic [W-1:0]  mul_lo;
    logic          mul_ovf;

    logic          in_ready_next;
    logic          out_valid_next;
    logic          busy_next;
    logic [W-1:0]  out_fact_next;
    logic          out_ovf_next;

    sat_mul #(.W(W), .NW(NW)) u_sat_mul (
        .a   (acc),
        .b   (cnt),
        .lo  (mul_lo),
        .ovf (mul_ovf)
    );

    // State, datapath and registered outputs; reset wins over accept and handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= W'(1);
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_fact  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            ovf       <= ovf_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
            busy      <= busy_next;
            out_fact  <= out_fact_next;
            out_ovf   <= out_ovf_next;
        end
    end

    // Next state and datapath; cnt<=1 ends the product so 0! and 1! both stay at 1.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = CALC;
                    acc_next   = W'(1);
                    cnt_next   = in_n;
                    ovf_next   = 1'b0;
                end
            end
            CALC: begin
                if (cnt > NW'(1)) begin
                    acc_next = mul_lo;
                    ovf_next = ovf | mul_ovf;
                    cnt_next = cnt - NW'(1);
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output values for the next cycle, decoded from the next state.
    always_comb begin
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        busy_next      = 1'b1;
        out_fact_next  = '0;
        out_ovf_next   = 1'b0;
        case (state_next)
            IDLE: begin
                in_ready_next = 1'b1;
                busy_next     = 1'b0;
            end
            DONE: begin
                out_valid_next = 1'b1;
                out_fact_next  = ovf_next ? {W{1'b1}} : acc_next;
                out_ovf_next   = ovf_next;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/factorial_engine.md
FACTORIAL_ENGINE -- requirements
Module: factorial_engine

Interface
REQ-001 Parameter: W, default 32, result width in bits.
REQ-002 Parameter: NW, default 8, operand width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  operand offered.
REQ-007 Port: in_n  input  NW  operand n (unsigned).
REQ-008 Port: in_ready  output  1  engine can accept an operand.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: out_fact  output  W  n! or saturated value.
REQ-012 Port: out_ovf  output  1  n! exceeded 2^W-1.
REQ-013 Port: busy  output  1  high in CALC or DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be high only in IDLE; an operand is accepted on a clock edge where in_valid and in_ready are both high.
REQ-016 On accept, the engine SHALL load acc=1, cnt=in_n and ovf=0, then enter CALC; in_n is sampled only at accept.
REQ-017 In CALC with cnt>1, each edge SHALL compute acc=acc*cnt (full W+NW-bit product, low W bits kept), set ovf sticky if any upper NW product bits are nonzero or ovf is already set, and decrement cnt.
REQ-018 In CALC with cnt<=1, the next edge SHALL move the FSM to DONE.
REQ-019 n=0 and n=1 SHALL both yield out_fact=1 with out_ovf=0 (0!=1).
REQ-020 out_valid SHALL rise exactly max(n,1) clock edges after the accepting edge, giving a fixed, data-dependent latency with no early termination.
REQ-021 In DONE, out_valid SHALL be high; out_fact SHALL equal acc, or all-ones if ovf=1; out_ovf SHALL equal ovf.
REQ-022 out_fact and out_ovf SHALL stay stable while out_valid is high and out_ready is low.
REQ-023 out_valid and out_ready both high SHALL return the FSM to IDLE on that edge.
REQ-024 No operand SHALL be accepted in the same cycle as a result handoff; in_ready rises the cycle after the handoff.
REQ-025 Outside DONE, out_fact and out_ovf SHALL be 0.
REQ-026 in_valid asserted while in CALC or DONE SHALL be ignored, with no effect on the result in progress.

Reset
REQ-027 rst high at a clock edge SHALL force IDLE, acc=1, cnt=0, ovf=0.
REQ-028 After reset: in_ready=1, out_valid=0, out_fact=0, out_ovf=0, busy=0.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation and discard any pending result; no out_valid SHALL follow.
REQ-030 rst SHALL take priority over accept and handoff in the same cycle.

Structure
REQ-031 A package factorial_pkg SHALL hold the state enum (IDLE/CALC/DONE) and the default constants W_DEF=32 and NW_DEF=8.
REQ-032 One sub-module, sat_mul, SHALL perform the W-by-NW multiply and return the low W bits plus an overflow flag; the FSM and registers stay in factorial_engine.
REQ-033 The implementation SHALL be fully synthesizable, with no recursion and one multiplier instance.

Verification
REQ-034 The bench SHALL cover: reset, then n=5 with out_ready=1 -> out_valid rises 5 edges after accept, out_fact=120, out_ovf=0.
REQ-035 The bench SHALL cover: n=0, then n=1 -> each gives out_fact=1, out_ovf=0, out_valid 1 edge after accept.
REQ-036 The bench SHALL cover (W=32): n=12 -> 479001600, ovf=0; n=13 -> out_fact=32'hFFFF_FFFF, ovf=1; n=255 -> same saturated result.
REQ-037 The bench SHALL cover: n=6 with out_ready held low for 10 cycles -> out_fact=720 held stable and in_ready=0 throughout; handoff, then in_ready=1 the next cycle.
REQ-038 The bench SHALL cover: n=10 accepted, rst pulsed for 1 cycle at accept+4 -> no out_valid, all outputs at reset values, then n=3 -> 6.
REQ-039 The bench SHALL cover: in_n changed and in_valid toggled during CALC -> result unaffected (n=7 -> 5040).
